// File: rtl/register_file.sv
// General-purpose register file: two combinational read ports, one write port, register 0 reads as zero.
// Latency: reads are combinational; a write is visible from the cycle after the edge, or in the same cycle when bypass is enabled.
// Backpressure: none; a write is accepted on every enabled rising edge.
module register_file #(
  parameter int dataWidth    = 32,
  parameter int addrWidth    = 5,
  parameter bit bypassEnable = 1'b1
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic [addrWidth-1:0] readReg1,
  input  logic [addrWidth-1:0] readReg2,
  input  logic [addrWidth-1:0] writeReg,
  input  logic [dataWidth-1:0] writeData,
  input  logic                 regWrite,
  output logic [dataWidth-1:0] readData1,
  output logic [dataWidth-1:0] readData2
);

  localparam int NumRegs = 2 ** addrWidth;

  logic [dataWidth-1:0] regs_q [NumRegs];
  logic [dataWidth-1:0] regs_d [NumRegs];
  logic                 wr_active;

  // A write only counts outside reset and never to index 0, so entry 0 stays zero forever.
  assign wr_active = resetN && regWrite && (writeReg != '0);

  // Next-state of the array: at most one entry replaced by writeData.
  always_comb begin
    regs_d = regs_q;
    if (wr_active) begin
      regs_d[writeReg] = writeData;
    end
  end

  // Array storage; reset clears every entry immediately and wins over a coincident clock edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read port 1: zero in reset or for index 0, else bypassed write data or the stored entry.
  always_comb begin
    readData1 = '0;
    if (resetN && (readReg1 != '0)) begin
      if (bypassEnable && wr_active && (readReg1 == writeReg)) begin
        readData1 = writeData;
      end else begin
        readData1 = regs_q[readReg1];
      end
    end
  end

  // Read port 2: same rule as port 1, evaluated independently.
  always_comb begin
    readData2 = '0;
    if (resetN && (readReg2 != '0)) begin
      if (bypassEnable && wr_active && (readReg2 == writeReg)) begin
        readData2 = writeData;
      end else begin
        readData2 = regs_q[readReg2];
      end
    end
  end

endmodule
